// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the nebula-core instruction fetch unit.
package ifu_pkg;

    // Width of an instruction word.
    localparam int INST_W = 32;

    // Default first fetch address after reset.
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Sequential fetch stride in bytes.
    localparam int PC_INC = 4;

    // Fetch FSM states: issue request, wait for response, hold for decode.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_out_reg.sv
// ifu_out_reg: {pc, data} pipeline holding register with valid/ready and flush.
// Loading has priority over draining; flush clears valid but leaves the payload
// untouched. Reset clears valid and payload.
module ifu_out_reg
    import ifu_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state: drain on handshake, load on new entry, flush wins over both.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (in_valid) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            data_d  = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Register with synchronous reset to an empty, zeroed entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_data  = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: nebula-core instruction fetch stage. Owns the PC, keeps at most one
// memory read outstanding, and presents {pc, inst} to decode.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; once valid is raised, payload holds stable until that transfer, except
// that a redirect may retarget a pending request or withdraw a held output.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;

    logic            req_fire;
    logic            out_fire;
    logic            load_out;
    logic            flush_out;
    logic [XLEN-1:0] redirect_tgt;

    // Redirect targets are forced word aligned.
    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    // Request is only offered in REQ, and never while reset is held.
    assign imem_req_valid = (state_q == ST_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_fire       = out_valid && out_ready;

    // Next-state logic: redirect has top priority in every state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        load_out  = 1'b0;
        flush_out = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (req_fire) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                    drop_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        load_out = 1'b1;
                        pc_d     = pc_q + XLEN'(PC_INC);
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d      = redirect_tgt;
                    flush_out = 1'b1;
                    state_d   = ST_REQ;
                end else if (out_fire) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    // FSM, PC and drop-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    ifu_out_reg #(
        .PC_W   (XLEN),
        .DATA_W (INST_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_out),
        .in_valid  (load_out),
        .in_pc     (pc_q),
        .in_data   (imem_resp_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_data  (out_inst)
    );

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    // Count decode handshakes and cycles spent waiting on memory.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_fire) begin
            fetch_cnt_d = fetch_cnt_q + 64'd1;
        end
        if ((state_q == ST_WAIT) && !imem_resp_valid) begin
            stall_cnt_d = stall_cnt_q + 64'd1;
        end
    end

    // Counter registers, wrapping at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with hand-computed expectations.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    int n_vec;
    int n_err;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full fetch with zero-wait memory and decode ready: REQ -> WAIT -> HOLD -> REQ.
    // Entry: just after an edge, state REQ at address a, req_ready=1, out_ready=1.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        #1;
        chk("req_valid", 64'(imem_req_valid), 64'd1);
        chk("req_addr", 64'(imem_req_addr), 64'(a));
        step();
        chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
        chk("wait_out_valid", 64'(out_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_out_pc", 64'(out_pc), 64'(a));
        chk("hold_out_inst", 64'(out_inst), 64'(d));
        step();
        chk("done_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;

        // Reset values.
        step();
        step();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(imem_req_addr), 64'h8000_0000);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);

        // Straight-line fetch from the reset vector.
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        fetch_one(32'h8000_0000, 32'h0000_0013);

        // Memory not ready for 4 cycles: address stable; stray response ignored.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_resp_valid = (i == 1);
            imem_resp_data  = 32'hBAD0_0000;
            #1;
            chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
            chk("stall_req_addr", 64'(imem_req_addr), 64'h8000_0004);
            step();
            chk("stall_out_valid", 64'(out_valid), 64'd0);
        end
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_req_ready  = 1'b1;
        fetch_one(32'h8000_0004, 32'h0010_0093);
        fetch_one(32'h8000_0008, 32'h0020_0113);

        // Decode stalls 5 cycles in HOLD: output stable, no new request.
        out_ready = 1'b0;
        #1;
        chk("bp_req_addr", 64'(imem_req_addr), 64'h8000_000C);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0030_0193;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_pc", 64'(out_pc), 64'h8000_000C);
            chk("bp_out_inst", 64'(out_inst), 64'h0030_0193);
            chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
            if (i < 4) step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_done_out_valid", 64'(out_valid), 64'd0);
        chk("bp_next_req_valid", 64'(imem_req_valid), 64'd1);
        chk("bp_next_req_addr", 64'(imem_req_addr), 64'h8000_0010);

        // Redirect while waiting; response arrives 2 cycles later and is dropped.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("rdw_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rdw_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("rdw_wait_req_valid", 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0001;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        chk("rdw_drop_out_valid", 64'(out_valid), 64'd0);
        chk("rdw_next_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rdw_next_req_addr", 64'(imem_req_addr), 64'h8000_0100);
        fetch_one(32'h8000_0100, 32'h0040_0213);

        // Redirect in the same cycle as the response: response dropped.
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0002;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h8000_0200;
        step();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        chk("rdr_out_valid", 64'(out_valid), 64'd0);
        chk("rdr_req_addr", 64'(imem_req_addr), 64'h8000_0200);
        fetch_one(32'h8000_0200, 32'h0050_0293);

        // Redirect in the same cycle as the decode handshake: instruction consumed.
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0060_0313;
        step();
        imem_resp_valid = 1'b0;
        chk("rdh_out_valid", 64'(out_valid), 64'd1);
        chk("rdh_out_pc", 64'(out_pc), 64'h8000_0204);
        chk("rdh_out_inst", 64'(out_inst), 64'h0060_0313);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0301;
        step();
        redirect_valid = 1'b0;
        chk("rdh_done_out_valid", 64'(out_valid), 64'd0);
        chk("rdh_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rdh_req_addr", 64'(imem_req_addr), 64'h8000_0300);

        // Redirect in REQ without handshake: address retargets next cycle.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("rdq_req_addr", 64'(imem_req_addr), 64'h8000_0400);

        // Redirect in HOLD without handshake: output withdrawn.
        out_ready = 1'b0;
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0070_0393;
        step();
        imem_resp_valid = 1'b0;
        chk("rdo_out_valid", 64'(out_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("rdo_withdrawn_out_valid", 64'(out_valid), 64'd0);
        chk("rdo_req_addr", 64'(imem_req_addr), 64'h8000_0500);

        // Redirect in REQ with handshake: in-flight response dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0600;
        step();
        redirect_valid = 1'b0;
        chk("rdf_req_valid", 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0003;
        step();
        imem_resp_valid = 1'b0;
        chk("rdf_out_valid", 64'(out_valid), 64'd0);
        chk("rdf_req_addr", 64'(imem_req_addr), 64'h8000_0600);

        // PC wraps silently from the top word to zero.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        fetch_one(32'hFFFF_FFFC, 32'h0080_0413);
        #1;
        chk("wrap_req_addr", 64'(imem_req_addr), 64'h0);

        // Reset while waiting: everything returns to reset values.
        step();
        chk("prerst_wait_req_valid", 64'(imem_req_valid), 64'd0);
        rst = 1'b1;
        step();
        chk("mrst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("mrst_req_addr", 64'(imem_req_addr), 64'h8000_0000);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_pc", 64'(out_pc), 64'd0);
        chk("mrst_out_inst", 64'(out_inst), 64'd0);
`ifdef IFU_PERF_CNT_EN
        chk("mrst_perf_fetch", perf_fetch_cnt, 64'd0);
        chk("mrst_perf_stall", perf_stall_cnt, 64'd0);
`endif
        rst = 1'b0;
        fetch_one(32'h8000_0000, 32'h0090_0493);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage of nebula-core. Owns the PC, issues one 32-bit instruction read at a time over a valid/ready memory port, and presents {pc, inst} to the decode stage over a valid/ready handshake.
- The decode stage consumes out_inst through its mux lookup tables.
- Accepts redirects (branch, jump or trap target) from later stages and discards stale responses.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_resp_valid  in  1  read data valid; memory cannot stall it.
- imem_resp_data  in  32  instruction word.
- out_valid  out  1  {out_pc, out_inst} valid to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  XLEN  PC of presented instruction.
- out_inst  out  32  presented instruction.
- redirect_valid  in  1  flush and refetch.
- redirect_pc  in  XLEN  new fetch target.

Behaviour:
- Reset: while rst is high, hold the following values:
  - state = REQ, pc = RESET_PC, drop = 0.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - out_valid = 0, out_pc = 0, out_inst = 0.
- Reset mid-operation abandons any outstanding request. A response arriving after reset is ignored unless the block is in WAIT; the memory must not respond to pre-reset requests.
- At most one request is outstanding. States are REQ, WAIT and HOLD.
- REQ:
  - Drive imem_req_valid = 1 and imem_req_addr = pc, starting from the first cycle after rst falls.
  - On req_valid & req_ready, go to WAIT.
  - Address stays stable while valid and not ready; the only exception is a redirect.
- WAIT:
  - imem_req_valid = 0.
  - On resp_valid with drop = 0: load out_pc = pc and out_inst = resp_data, set out_valid = 1, set pc = pc + 4 (mod 2^XLEN, wraps silently), go to HOLD.
  - On resp_valid with drop = 1: discard the data, clear drop, go to REQ.
- HOLD:
  - out_valid = 1 with out_pc and out_inst stable until out_ready.
  - On handshake: clear out_valid next cycle and go to REQ.
- Latency: next request is issued the cycle after the decode handshake. Best case is 3 cycles per instruction with a zero-wait memory.
- Redirect has the highest priority. The target pc is redirect_pc with bits [1:0] forced to 0.
  - In REQ without handshake: pc updates; the next cycle's address is the new pc.
  - In REQ with handshake in the same cycle: go to WAIT with drop = 1.
  - In WAIT with no response: set drop = 1 and stay in WAIT.
  - In WAIT with a response in the same cycle: drop that response and go to REQ.
  - In HOLD without handshake: out_valid = 0 next cycle, go to REQ.
  - In HOLD with handshake in the same cycle: the instruction counts as consumed; go to REQ at the redirect target.
- imem_resp_valid outside WAIT is ignored.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- When defined: add output ports perf_fetch_cnt[63:0] and perf_stall_cnt[63:0].
  - perf_fetch_cnt increments on each out handshake.
  - perf_stall_cnt increments on each cycle in WAIT without resp_valid.
  - Both reset to 0 and wrap at 2^64.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ifu_pkg holds:
  - the state enum {REQ, WAIT, HOLD} as 2 bits;
  - localparam INST_W = 32 and the RESET_PC default;
  - the PC increment constant of 4.
- One sub-module, ifu_out_reg: the {pc, inst} holding register with valid/ready and a flush input. It is reusable for later pipeline registers.

Test Plan:
- Reset release, req_ready = 1, 1-cycle response, out_ready = 1 → addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 fetched; out_inst matches memory; one instruction every 3 cycles.
- out_ready held low 5 cycles in HOLD → out_valid, out_pc and out_inst stable; no new imem request until the handshake.
- req_ready low 4 cycles → imem_req_addr stable at 0x8000_0004 throughout; exactly one request accepted.
- Redirect to 0x8000_0102 while in WAIT, response 2 cycles later → response discarded, out_valid stays 0, next request addr = 0x8000_0100.
- Redirect in the same cycle as resp_valid, and separately in the same cycle as the out handshake → response dropped in the first case, instruction consumed in the second; next fetch = redirect target.
- Assert rst while in WAIT → outputs return to reset values next cycle; first post-reset request at 0x8000_0000. With IFU_PERF_CNT_EN, the counters read 0.
